uart_wb_arbiter: RTL and testbench

- Two-master Wishbone arbiter and bus-cycle sequencer in front of uart_control's slave port.
- Shares the single UART register window (0x60xx_xxxx..0x63xx_xxxx) between master 0 (CPU) and master 1 (print/poll engine).
- Adds a no-acknowledge watchdog: unpopulated UART groups (0x62/0x63) never ack, so a hung cycle is terminated with an error.

---
 rtl/uart_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_wb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the UART register window with a no-ack watchdog.
// Grant lands 1 cycle after request; the owner's signals then pass combinationally to the slave.
module uart_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_CNT_W       = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic [31:0]         m0_adr_i,
    input  logic [31:0]         m0_dat_i,
    output logic [31:0]         m0_dat_o,
    input  logic                m0_we_i,
    input  logic [3:0]          m0_sel_i,
    input  logic                m0_stb_i,
    input  logic                m0_cyc_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic [31:0]         m1_adr_i,
    input  logic [31:0]         m1_dat_i,
    output logic [31:0]         m1_dat_o,
    input  logic                m1_we_i,
    input  logic [3:0]          m1_sel_i,
    input  logic                m1_stb_i,
    input  logic                m1_cyc_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic                s_we_o,
    output logic                s_stb_o,
    output logic                s_cyc_o,
    output logic [3:0]          s_sel_o,
    input  logic [31:0]         s_dat_i,
    input  logic                s_ack_i,
    output logic [1:0]          grant_o,
    output logic [TO_CNT_W-1:0] to_cnt_o
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_owner;
    logic                w_last_owner_nxt;
    logic [WD_W-1:0]     r_wd_cnt;
    logic                r_err;
    logic [TO_CNT_W-1:0] r_to_cnt;

    logic w_own0;
    logic w_own1;
    logic w_own_stb;
    logic w_own_cyc;
    logic w_active;
    logic w_timeout;

    assign w_own0    = (r_state == ST_OWN0);
    assign w_own1    = (r_state == ST_OWN1);
    assign w_own_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
    assign w_own_cyc = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
    assign w_active  = w_own_stb & w_own_cyc;
    // An ack on the terminal-count cycle wins; the err cycle itself never times out.
    assign w_timeout = w_active & ~s_ack_i & ~r_err & (r_wd_cnt == WD_LAST);

    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_err <= w_timeout;
            if (!w_active || s_ack_i || w_timeout || r_err) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
            if (w_timeout && (r_to_cnt != {TO_CNT_W{1'b1}})) begin
                r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
            end
        end
    end

    assign s_adr_o = w_own0 ? m0_adr_i : (w_own1 ? m1_adr_i : 32'h0);
    assign s_dat_o = w_own0 ? m0_dat_i : (w_own1 ? m1_dat_i : 32'h0);
    assign s_we_o  = (w_own0 & m0_we_i) | (w_own1 & m1_we_i);
    assign s_sel_o = w_own0 ? m0_sel_i : (w_own1 ? m1_sel_i : 4'h0);
    // The slave strobe is withdrawn on the err cycle so a late ack cannot land.
    assign s_stb_o = w_own_stb & ~r_err;
    assign s_cyc_o = w_own_cyc & ~r_err;

    assign m0_dat_o = w_own0 ? s_dat_i : 32'h0;
    assign m1_dat_o = w_own1 ? s_dat_i : 32'h0;
    assign m0_ack_o = w_own0 & s_ack_i & m0_stb_i & m0_cyc_i & ~r_err;
    assign m1_ack_o = w_own1 & s_ack_i & m1_stb_i & m1_cyc_i & ~r_err;
    assign m0_err_o = w_own0 & r_err;
    assign m1_err_o = w_own1 & r_err;

    assign grant_o  = {w_own1, w_own0};
    assign to_cnt_o = r_to_cnt;

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed bench for uart_wb_arbiter: arbitration order, tenure hold, watchdog, saturation, async reset.
module tb_uart_wb_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
    logic [3:0]  m0_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
    logic [3:0]  m1_sel_i;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;
    logic [7:0]  to_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    uart_wb_arbiter #(.TIMEOUT_CYCLES(16), .TO_CNT_W(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
        .s_cyc_o(s_cyc_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .to_cnt_o(to_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        logic seen;
        wb_rst_n_i = 1'b0;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_sel_i = '0; m0_stb_i = 0; m0_cyc_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = '0; m1_stb_i = 0; m1_cyc_i = 0;
        s_dat_i = '0; s_ack_i = 0;

        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_s_stb", 32'(s_stb_o), 32'h0);
        chk("rst_to_cnt", 32'(to_cnt_o), 32'h0);
        chk("rst_m0_dat", m0_dat_o, 32'h0);
        wb_rst_n_i = 1'b1;

        // Single m0 read, slave acks on the fourth strobe cycle.
        tick();
        m0_adr_i = 32'h6000_0004; m0_sel_i = 4'hF; m0_stb_i = 1; m0_cyc_i = 1;
        #1;
        chk("rd_grant_lat", 32'(grant_o), 32'h0);
        chk("rd_stb_lat", 32'(s_stb_o), 32'h0);
        tick(); #1;
        chk("rd_grant", 32'(grant_o), 32'h1);
        chk("rd_s_adr", s_adr_o, 32'h6000_0004);
        chk("rd_s_stb", 32'(s_stb_o), 32'h1);
        chk("rd_noack0", 32'(m0_ack_o), 32'h0);
        tick(); tick();
        s_ack_i = 1; s_dat_i = 32'h0000_00A5;
        #1;
        chk("rd_ack", 32'(m0_ack_o), 32'h1);
        chk("rd_dat", m0_dat_o, 32'h0000_00A5);
        chk("rd_m1_dat", m1_dat_o, 32'h0);
        chk("rd_m1_ack", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
        #1;
        chk("rd_ack_pulse", 32'(m0_ack_o), 32'h0);
        tick(); #1;
        chk("rd_release", 32'(grant_o), 32'h0);

        // Simultaneous requests straight out of reset: m0 first, then m1, then m0 again.
        wb_rst_n_i = 0; #1; wb_rst_n_i = 1;
        m0_stb_i = 1; m0_cyc_i = 1; m1_stb_i = 1; m1_cyc_i = 1; m1_adr_i = 32'h6100_0008;
        #1;
        tick(); #1;
        chk("rr_first_m0", 32'(grant_o), 32'h1);
        m0_stb_i = 0; m0_cyc_i = 0;
        tick(); #1;
        chk("rr_idle_gap", 32'(grant_o), 32'h0);
        tick(); #1;
        chk("rr_then_m1", 32'(grant_o), 32'h2);
        chk("rr_m1_adr", s_adr_o, 32'h6100_0008);
        m1_stb_i = 0; m1_cyc_i = 0;
        tick();
        m0_stb_i = 1; m0_cyc_i = 1; m1_stb_i = 1; m1_cyc_i = 1;
        #1;
        chk("rr_idle2", 32'(grant_o), 32'h0);
        tick(); #1;
        chk("rr_again_m0", 32'(grant_o), 32'h1);
        m0_stb_i = 0; m0_cyc_i = 0; m1_stb_i = 0; m1_cyc_i = 0;
        tick(); #1;
        chk("rr_idle3", 32'(grant_o), 32'h0);

        // m1 locks the bus for four acked writes while m0 waits (last owner is m0, so m1 wins).
        m1_adr_i = 32'h6100_0000; m1_we_i = 1; m1_sel_i = 4'h1; m1_stb_i = 1; m1_cyc_i = 1;
        m0_adr_i = 32'h6000_0000; m0_stb_i = 1; m0_cyc_i = 1;
        tick(); #1;
        chk("lk_grant", 32'(grant_o), 32'h2);
        for (int i = 0; i < 4; i++) begin
            m1_dat_i = 32'h1000 + 32'(i); s_ack_i = 1;
            #1;
            chk("lk_m1_ack", 32'(m1_ack_o), 32'h1);
            chk("lk_hold", 32'(grant_o), 32'h2);
            chk("lk_s_dat", s_dat_o, 32'h1000 + 32'(i));
            chk("lk_m0_ack", 32'(m0_ack_o), 32'h0);
            tick();
        end
        s_ack_i = 0; m1_stb_i = 0; m1_cyc_i = 0; m1_we_i = 0;
        #1;
        chk("lk_last", 32'(grant_o), 32'h2);
        tick(); #1;
        chk("lk_idle", 32'(grant_o), 32'h0);
        tick(); #1;
        chk("lk_m0_won", 32'(grant_o), 32'h1);
        m0_stb_i = 0; m0_cyc_i = 0;
        tick();

        // Timeout on an unpopulated group: err 16 cycles after the strobe reaches the slave.
        m0_adr_i = 32'h6200_0000; m0_stb_i = 1; m0_cyc_i = 1;
        tick(); #1;
        chk("to_stb_up", 32'(s_stb_o), 32'h1);
        for (int k = 1; k < 16; k++) begin
            tick(); #1;
            chk("to_no_err_early", 32'(m0_err_o), 32'h0);
        end
        tick(); #1;
        chk("to_err", 32'(m0_err_o), 32'h1);
        chk("to_stb_forced", 32'(s_stb_o), 32'h0);
        chk("to_cyc_forced", 32'(s_cyc_o), 32'h0);
        chk("to_no_ack", 32'(m0_ack_o), 32'h0);
        chk("to_cnt1", 32'(to_cnt_o), 32'h1);
        tick(); #1;
        chk("to_err_pulse", 32'(m0_err_o), 32'h0);
        chk("to_stb_back", 32'(s_stb_o), 32'h1);
        m0_stb_i = 0; m0_cyc_i = 0;
        tick();

        // Ack on the terminal-count cycle beats the watchdog.
        m0_stb_i = 1; m0_cyc_i = 1;
        tick();
        repeat (15) tick();
        s_ack_i = 1;
        #1;
        chk("tc_ack", 32'(m0_ack_o), 32'h1);
        chk("tc_no_err", 32'(m0_err_o), 32'h0);
        s_ack_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
        tick(); #1;
        chk("tc_no_err_next", 32'(m0_err_o), 32'h0);
        chk("tc_cnt_same", 32'(to_cnt_o), 32'h1);
        chk("tc_idle", 32'(grant_o), 32'h0);

        // 300 further timeouts: counter passes 201 and then pins at all-ones.
        m0_stb_i = 1; m0_cyc_i = 1;
        for (int n = 0; n < 300; n++) begin
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick(); #1;
                if (m0_err_o) seen = 1;
            end
            chk("sat_err_seen", 32'(seen), 32'h1);
            if (n == 199) chk("sat_cnt201", 32'(to_cnt_o), 32'd201);
        end
        chk("sat_cnt255", 32'(to_cnt_o), 32'hFF);
        m0_stb_i = 0; m0_cyc_i = 0;
        tick(); tick();

        // Async reset during an m1 tenure, then clean re-arbitration.
        m1_adr_i = 32'h6100_0010; m1_stb_i = 1; m1_cyc_i = 1;
        tick(); #1;
        chk("ar_grant", 32'(grant_o), 32'h2);
        tick(); tick(); tick(); #1;
        wb_rst_n_i = 0;
        #1;
        chk("ar_cyc_drop", 32'(s_cyc_o), 32'h0);
        chk("ar_stb_drop", 32'(s_stb_o), 32'h0);
        chk("ar_grant_drop", 32'(grant_o), 32'h0);
        chk("ar_cnt_clr", 32'(to_cnt_o), 32'h0);
        #1;
        wb_rst_n_i = 1;
        tick(); #1;
        chk("ar_regrant", 32'(grant_o), 32'h2);
        chk("ar_no_err", 32'(m1_err_o), 32'h0);
        chk("ar_cnt0", 32'(to_cnt_o), 32'h0);
        m1_stb_i = 0; m1_cyc_i = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
